line_attr_buffer: RTL and testbench
===================================

LINE_ATTR_BUFFER -- requirements
Module: line_attr_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 2: attribute bits per entry.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8: log2 of entries per line (DEPTH = 2**DEPTH_LOG2).
REQ-003 SHALL have parameter PRIO, default 1: 1 = first write to an entry wins; 0 = last write wins.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port swap  input  1  single-cycle pulse that exchanges write and read banks.
REQ-007 SHALL have port wr_idx  input  DEPTH_LOG2  write entry index.
REQ-008 SHALL have port wr_data  input  WIDTH  write attribute.
REQ-009 SHALL have port wr_en  input  1  write strobe.
REQ-010 SHALL have port rd_idx  input  DEPTH_LOG2  read entry index.
REQ-011 SHALL have port rd_data  output  WIDTH  registered attribute from the read bank.
REQ-012 SHALL have port rd_hit  output  1  registered written flag of the read entry.
REQ-013 SHALL have port clr_busy  output  1  clear sweep in progress.
REQ-014 SHALL have port collision  output  1  a collision occurred on the line now in the read bank.
REQ-015 SHALL have port bank  output  1  index of the current write bank.

Function
REQ-016 SHALL hold two banks of DEPTH entries; each entry is WIDTH data bits plus one written flag.
REQ-017 SHALL write, on wr_en with clr_busy=0, wr_data to write-bank entry wr_idx and set its written flag.
REQ-018 SHALL, when PRIO=1 and the target written flag is already set, suppress the write; stored data stays unchanged.
REQ-019 SHALL, when PRIO=0, overwrite the entry regardless of its written flag.
REQ-020 SHALL set an internal collision accumulator on any accepted-or-suppressed wr_en hitting an entry whose written flag is set, in either PRIO mode.
REQ-021 SHALL drop wr_en while clr_busy=1; a dropped write does not affect the collision accumulator.
REQ-022 SHALL register rd_data/rd_hit from read-bank entry rd_idx with 1-cycle latency.
REQ-023 SHALL return rd_data=0 and rd_hit=0 for any entry not written since its last clear.
REQ-024 SHALL, on swap, toggle bank at that edge, copy the accumulator (including any same-cycle collision) into collision, and clear the accumulator.
REQ-025 SHALL apply a wr_en coincident with swap to the pre-swap write bank, and a read coincident with swap to the pre-swap read bank.
REQ-026 SHALL, from the edge after swap, assert clr_busy and clear the new write bank one entry per cycle, indices 0..DEPTH-1, for exactly DEPTH cycles.
REQ-027 SHALL, on swap while clr_busy=1, restart the sweep at index 0 on the newly selected bank; the bank leaving write role keeps its partially cleared contents.
REQ-028 SHALL wrap the sweep counter only by restart; no wrap-around clear beyond DEPTH entries.
REQ-029 SHALL implement storage as inferred distributed RAM with asynchronous read at wr_idx for the written-flag check; storage is not reset by reset_n.

Reset
REQ-030 SHALL, while reset_n=0, force bank=0, collision=0, accumulator=0, rd_data=0, rd_hit=0, clr_busy=1, and sweep counter=0.
REQ-031 SHALL, after reset_n rises, clear both banks simultaneously over DEPTH cycles, then drop clr_busy.
REQ-032 SHALL abort any sweep or pending write immediately on reset_n assertion mid-operation and restart the dual-bank clear on release.

Verification
REQ-033 SHALL cover: reset release with defaults -> clr_busy high for 256 cycles, then low; reads of all entries in both banks (across one swap) -> rd_data=0, rd_hit=0.
REQ-034 SHALL cover: PRIO=1, write idx 0x40 data 2, then idx 0x40 data 1, swap, wait for clear, read 0x40 -> rd_data=2, rd_hit=1, collision=1.
REQ-035 SHALL cover: PRIO=0, same sequence -> rd_data=1, collision=1; next swap with no collisions -> collision=0.
REQ-036 SHALL cover: wr_en idx 0xFF data 3 in the swap cycle -> data lands in the bank now read; rd_idx 0xFF reads 3 one cycle later.
REQ-037 SHALL cover: swap at sweep index 100, then wait 256 cycles -> clr_busy low exactly 256 cycles after the second swap; old bank entries 100..255 retain prior data.
REQ-038 SHALL cover: wr_en during clr_busy -> write dropped; entry reads rd_hit=0 after the next swap.

Source files
------------

// File: rtl/line_attr_buffer.sv
// line_attr_buffer
//   Double-banked per-line attribute store. One bank takes writes while the
//   other is read. A swap pulse exchanges the roles, and the bank that becomes
//   the write bank is then swept clear one entry per cycle.
//   Each entry holds WIDTH data bits plus a "written" flag. With PRIO=1 the
//   first write to an entry wins; with PRIO=0 the last write wins. Hitting an
//   already-written entry counts as a collision. The collision status of a line
//   is reported once that line moves to the read bank.
//
// Parameters
//   WIDTH      attribute bits per entry
//   DEPTH_LOG2 log2 of the number of entries per line
//   PRIO       1 = first write wins, 0 = last write wins
//
// Ports
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   swap       single-cycle pulse that exchanges the write and read banks
//   wr_idx     write entry index
//   wr_data    write attribute
//   wr_en      write strobe (dropped while clr_busy is high)
//   rd_idx     read entry index
//   rd_data    registered attribute from the read bank (1-cycle latency)
//   rd_hit     registered written flag of the read entry
//   clr_busy   clear sweep in progress
//   collision  a collision occurred on the line now in the read bank
//   bank       index of the current write bank
module line_attr_buffer #(
  parameter int WIDTH      = 2,
  parameter int DEPTH_LOG2 = 8,
  parameter int PRIO       = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  swap,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_hit,
  output logic                  clr_busy,
  output logic                  collision,
  output logic                  bank
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE,     // no sweep running
    ST_CLR_ALL,  // post-reset sweep, clears both banks together
    ST_CLR_WR    // post-swap sweep, clears the current write bank only
  } state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] clr_idx;
  logic                  acc;

  // {written flag, data}; storage is not reset, the sweeps clear it
  logic [WIDTH:0] mem0 [DEPTH];
  logic [WIDTH:0] mem1 [DEPTH];

  logic wr_flag;
  logic wr_take;
  logic wr_coll;
  logic wr_store;
  logic clr_go;
  logic clr0;
  logic clr1;

  always_comb begin
    wr_flag  = bank ? mem1[wr_idx][WIDTH] : mem0[wr_idx][WIDTH];
    wr_take  = wr_en & ~clr_busy & reset_n;
    wr_coll  = wr_take & wr_flag;
    wr_store = wr_take & ~((PRIO != 0) & wr_flag);
    // The swap edge itself performs no clear. A restarted sweep begins at the
    // following edge, and the bank leaving write role keeps entries
    // clr_idx..DEPTH-1 untouched.
    clr_go   = clr_busy & ~swap & reset_n;
    clr0     = clr_go & ((state == ST_CLR_ALL) | ((state == ST_CLR_WR) & ~bank));
    clr1     = clr_go & ((state == ST_CLR_ALL) | ((state == ST_CLR_WR) &  bank));
  end

  always_ff @(posedge clk) begin
    if (clr0) begin
      mem0[clr_idx] <= '0;
    end else if (wr_store && !bank) begin
      mem0[wr_idx] <= {1'b1, wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (clr1) begin
      mem1[clr_idx] <= '0;
    end else if (wr_store && bank) begin
      mem1[wr_idx] <= {1'b1, wr_data};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_CLR_ALL;
      clr_busy  <= 1'b1;
      clr_idx   <= '0;
      bank      <= 1'b0;
      collision <= 1'b0;
      acc       <= 1'b0;
      rd_data   <= '0;
      rd_hit    <= 1'b0;
    end else begin
      // read bank is the one not selected by bank
      {rd_hit, rd_data} <= bank ? mem0[rd_idx] : mem1[rd_idx];

      if (swap) begin
        bank      <= ~bank;
        collision <= acc | wr_coll;
        acc       <= 1'b0;
        state     <= ST_CLR_WR;
        clr_busy  <= 1'b1;
        clr_idx   <= '0;
      end else begin
        if (wr_coll) begin
          acc <= 1'b1;
        end
        if (clr_busy) begin
          if (clr_idx == '1) begin
            // counter parks at the last index; only a restart returns it to 0
            state    <= ST_IDLE;
            clr_busy <= 1'b0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_line_attr_buffer.sv
module tb_line_attr_buffer;

  localparam int WIDTH = 2;
  localparam int DL    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          swap;
  logic          wr_en;
  logic [DL-1:0] wr_idx;
  logic [DL-1:0] rd_idx;
  logic [1:0]    wr_data;

  logic [1:0] rd_data1, rd_data0;
  logic       rd_hit1, rd_hit0, clr_busy1, clr_busy0, coll1, coll0, bank1, bank0;

  line_attr_buffer #(.WIDTH(WIDTH), .DEPTH_LOG2(DL), .PRIO(1)) dut_p1 (
    .clk(clk), .reset_n(reset_n), .swap(swap), .wr_idx(wr_idx), .wr_data(wr_data),
    .wr_en(wr_en), .rd_idx(rd_idx), .rd_data(rd_data1), .rd_hit(rd_hit1),
    .clr_busy(clr_busy1), .collision(coll1), .bank(bank1)
  );

  line_attr_buffer #(.WIDTH(WIDTH), .DEPTH_LOG2(DL), .PRIO(0)) dut_p0 (
    .clk(clk), .reset_n(reset_n), .swap(swap), .wr_idx(wr_idx), .wr_data(wr_data),
    .wr_en(wr_en), .rd_idx(rd_idx), .rd_data(rd_data0), .rd_hit(rd_hit0),
    .clr_busy(clr_busy0), .collision(coll0), .bank(bank0)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic void check(string nm, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  // ---------------- reference model ----------------
  // Banks are modelled as plain arrays [prio][bank][idx]. A sweep is tracked
  // only by its start edge: entries cleared so far = edges elapsed since it
  // started, and the clear is applied lazily when the bank is next used.
  logic [1:0] m_data [2][2][DEPTH];
  bit         m_wr   [2][2][DEPTH];
  bit         m_acc  [2];
  bit         m_coll [2];
  bit         m_wb;
  bit [1:0]   pend;
  int         sw_start;
  int         edge_n = 0;

  typedef struct { logic [1:0] d1; bit h1; logic [1:0] d0; bit h0; int idx; } rd_exp_t;
  typedef struct { bit busy; bit bnk; bit c1; bit c0; } st_exp_t;
  rd_exp_t rd_q[$];
  st_exp_t st_q[$];

  function automatic void materialize(int e);
    int prog = e - sw_start - 1;
    if (prog > DEPTH) prog = DEPTH;
    if (prog < 0) prog = 0;
    for (int b = 0; b < 2; b++)
      if (pend[b])
        for (int i = 0; i < prog; i++)
          for (int p = 0; p < 2; p++) begin
            m_data[p][b][i] = 2'd0;
            m_wr[p][b][i]   = 1'b0;
          end
    pend = 2'b00;
  endfunction

  function automatic void model_reset();
    m_wb     = 1'b0;
    m_acc[0] = 0; m_acc[1] = 0;
    m_coll[0] = 0; m_coll[1] = 0;
    pend     = 2'b11;
    sw_start = edge_n;
  endfunction

  function automatic void model_edge(bit sw, bit we, int widx, int wd, bit re, int ridx);
    int e = edge_n;
    bit busy_pre = (e - sw_start) <= DEPTH;
    int wb = m_wb ? 1 : 0;
    int rb = m_wb ? 0 : 1;
    rd_exp_t r;
    st_exp_t s;
    if (re) begin
      if (!busy_pre) materialize(e);
      r.d1 = m_data[1][rb][ridx]; r.h1 = m_wr[1][rb][ridx];
      r.d0 = m_data[0][rb][ridx]; r.h0 = m_wr[0][rb][ridx];
      r.idx = ridx;
      rd_q.push_back(r);
    end
    if (we && !busy_pre) begin
      materialize(e);
      for (int p = 0; p < 2; p++) begin
        if (m_wr[p][wb][widx]) m_acc[p] = 1'b1;
        if (!m_wr[p][wb][widx] || p == 0) begin
          m_data[p][wb][widx] = wd[1:0];
          m_wr[p][wb][widx]   = 1'b1;
        end
      end
    end
    if (sw) begin
      materialize(e);
      for (int p = 0; p < 2; p++) begin
        m_coll[p] = m_acc[p];
        m_acc[p]  = 1'b0;
      end
      m_wb     = ~m_wb;
      pend     = m_wb ? 2'b10 : 2'b01;
      sw_start = e;
    end
    s.busy = (e - sw_start) < DEPTH;
    s.bnk  = m_wb;
    s.c1   = m_coll[1];
    s.c0   = m_coll[0];
    st_q.push_back(s);
  endfunction

  // ---------------- monitor ----------------
  bit rd_en = 0, st_en = 0;
  bit rd_vld = 0, st_vld = 0;
  always @(posedge clk) begin
    rd_vld <= rd_en;
    st_vld <= st_en;
  end

  always @(negedge clk) begin
    st_exp_t s;
    rd_exp_t r;
    if (st_vld) begin
      if (st_q.size() == 0) check("status_queue_underflow", 0, 1);
      else begin
        s = st_q.pop_front();
        check($sformatf("clr_busy_p1@%0d", edge_n), int'(clr_busy1), int'(s.busy));
        check($sformatf("clr_busy_p0@%0d", edge_n), int'(clr_busy0), int'(s.busy));
        check($sformatf("bank_p1@%0d", edge_n), int'(bank1), int'(s.bnk));
        check($sformatf("bank_p0@%0d", edge_n), int'(bank0), int'(s.bnk));
        check($sformatf("collision_p1@%0d", edge_n), int'(coll1), int'(s.c1));
        check($sformatf("collision_p0@%0d", edge_n), int'(coll0), int'(s.c0));
      end
    end
    if (rd_vld) begin
      if (rd_q.size() == 0) check("read_queue_underflow", 0, 1);
      else begin
        r = rd_q.pop_front();
        check($sformatf("rd_data_p1[%0h]", r.idx), int'(rd_data1), int'(r.d1));
        check($sformatf("rd_hit_p1[%0h]", r.idx), int'(rd_hit1), int'(r.h1));
        check($sformatf("rd_data_p0[%0h]", r.idx), int'(rd_data0), int'(r.d0));
        check($sformatf("rd_hit_p0[%0h]", r.idx), int'(rd_hit0), int'(r.h0));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit sw, input bit we, input int widx, input int wd,
                      input bit re, input int ridx);
    swap    = sw;
    wr_en   = we;
    wr_idx  = widx[DL-1:0];
    wr_data = wd[1:0];
    rd_idx  = ridx[DL-1:0];
    rd_en   = re;
    st_en   = 1'b1;
    edge_n++;
    model_edge(sw, we, widx, wd, re, ridx);
    @(posedge clk);
    #1;
    swap  = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, i);
  endtask

  task automatic do_reset();
    st_en = 1'b0; rd_en = 1'b0; swap = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("reset_bank_p1", int'(bank1), 0);
    check("reset_bank_p0", int'(bank0), 0);
    check("reset_clr_busy_p1", int'(clr_busy1), 1);
    check("reset_clr_busy_p0", int'(clr_busy0), 1);
    check("reset_collision_p1", int'(coll1), 0);
    check("reset_collision_p0", int'(coll0), 0);
    check("reset_rd_data_p1", int'(rd_data1), 0);
    check("reset_rd_hit_p0", int'(rd_hit0), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    reset_n = 1'b0; swap = 1'b0; wr_en = 1'b0;
    wr_idx = '0; wr_data = '0; rd_idx = '0;
    do_reset();

    // post-reset dual-bank clear, then every entry of both banks reads empty
    idle(DEPTH);
    read_all();
    step(1, 0, 0, 0, 0, 0);
    idle(DEPTH);
    read_all();

    // double write to 0x40: first-wins vs last-wins, collision reported
    step(0, 1, 'h40, 2, 0, 0);
    step(0, 1, 'h40, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(DEPTH);
    step(0, 0, 0, 0, 1, 'h40);

    // a line with no collisions reports collision=0
    step(1, 0, 0, 0, 0, 0);
    idle(DEPTH);

    // write in the swap cycle lands in the bank that becomes the read bank
    step(1, 1, 'hFF, 3, 0, 0);
    step(0, 0, 0, 0, 1, 'hFF);

    // write during a sweep is dropped
    step(0, 1, 5, 3, 0, 0);
    idle(DEPTH);
    step(0, 1, 7, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5);
    step(0, 0, 0, 0, 1, 7);

    // swap mid-sweep at index 100: old bank keeps entries 100..255
    idle(DEPTH);
    for (int i = 0; i < DEPTH; i++) step(0, 1, i, $urandom_range(0, 3), 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(DEPTH);
    step(1, 0, 0, 0, 0, 0);
    idle(100);
    step(1, 0, 0, 0, 0, 0);
    read_all();
    idle(4);

    // randomized traffic on a narrow index range to provoke collisions
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15), $urandom_range(0, 3),
           $urandom_range(0, 1) == 1, $urandom_range(0, 15));
    end

    // reset mid-operation clears the accumulator and restarts the dual clear
    idle(DEPTH);
    step(0, 1, 3, 1, 0, 0);
    step(0, 1, 3, 2, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(40);
    do_reset();
    idle(DEPTH);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, i);

    st_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("read_queue_drained", rd_q.size(), 0);
    check("status_queue_drained", st_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
